sfp_rx_deframer: RTL
====================

// Module: sfp_rx_deframer
// PURPOSE
//  Consumes the word-aligned 32-bit stream plus 4-bit K-flags from the SFP lane-align stage.
//  Delineates frames by K-character SOF/EOF, strips the header and checksum, and emits payload words as a valid/last stream.
//  Reports per-frame ok/err status and keeps a saturating error count.
//  The stream cannot be stalled, so the consumer must accept m_data on every cycle where m_valid=1.
// PARAMETERS
//  MAX_LEN   256  maximum payload length in words; a header LEN above this is an error
//  CNT_W     16   width of err_cnt
// PORTS
//  clk        in   1      core clock, same domain as the align stage
//  rst        in   1      asynchronous, active-high reset
//  rxd        in   32     aligned data; byte0 = rxd[7:0] is first on the wire
//  rxctl      in   4      aligned K-flags; bit i marks byte i as K-char
//  m_data     out  32     payload word
//  m_valid    out  1      m_data valid
//  m_last     out  1      final payload word of a frame (qualified by m_valid)
//  m_type     out  8      TYPE field of the current frame; stable from header until the next SOF
//  frame_ok   out  1      1-cycle pulse: frame completed, checksum good
//  frame_err  out  1      1-cycle pulse: frame dropped or aborted
//  err_code   out  3      cause, valid with frame_err: 1=len>MAX, 2=K in body, 3=csum, 4=no EOF, 5=SOF in frame
//  err_cnt    out  CNT_W  count of frame_err pulses, saturates at all-ones
// BEHAVIOUR
//  Control words (ctl=4'b0001 only): IDLE byte0=8'hBC, SOF byte0=8'hFB, EOF byte0=8'hFD; rxd[31:8] ignored.
//  A data word has ctl=4'h0. Any other nonzero ctl is treated as a K in the body.
//  Frame layout: SOF, HDR{LEN[31:16],TYPE[15:8],SEQ[7:0]}, LEN payload words, CSUM, EOF.
//  CSUM = sum mod 2^32 of HDR and all payload words.
//  Reset: all outputs 0; FSM=S_IDLE; accumulators 0.
//  FSM:
//   S_IDLE: SOF -> S_HDR; everything else ignored.
//   S_HDR: data word -> latch LEN/TYPE; sum=HDR; remaining=LEN.
//    LEN>MAX_LEN -> err 1 -> S_IDLE.
//    LEN=0 -> S_CSUM; otherwise -> S_DATA.
//   S_DATA: data word -> emit; sum+=word; remaining-=1; remaining becomes 0 -> S_CSUM.
//   S_CSUM: data word -> compare with sum, hold the result -> S_EOF.
//   S_EOF: EOF -> frame_ok if csum matched, else err 3 -> S_IDLE.
//    Data word or IDLE -> err 4 -> S_IDLE.
//  Any K word other than SOF in S_HDR/S_DATA/S_CSUM -> err 2 -> S_IDLE.
//  SOF in any non-IDLE state -> err 5 and resync: go to S_HDR (the new frame is accepted).
//  Latency: a payload word at the input on cycle t appears on m_data/m_valid at t+1 (one register stage).
//  m_last is set with the word where remaining goes 1->0. LEN=0 emits no m_valid.
//  frame_ok/frame_err assert at t+1 after the deciding input word. They never assert together.
//  At most one pulse per frame.
//  Abort mid-payload: m_last is never produced for that frame. The consumer discards on frame_err.
//  err_cnt increments on each frame_err and holds at 2^CNT_W-1.
//  m_data holds its last value when m_valid=0.
//  Reset mid-frame: all state clears immediately. Words before the next SOF are ignored.
// TESTING
//  1. Idles, then SOF, HDR=32'h0003_A501, payload 1,2,3, CSUM=32'h0003_A507, EOF
//     -> m_valid 3 cycles with data 1,2,3; m_last on 3; m_type=8'hA5; frame_ok 1 cycle after EOF.
//  2. Same frame with CSUM=32'h0 -> payload still emitted; frame_err with err_code=3; err_cnt=1.
//  3. HDR LEN=0, CSUM=HDR, EOF -> no m_valid; frame_ok.
//     Then HDR LEN=MAX_LEN+1 -> frame_err with code 1, followed by no payload output.
//  4. LEN=4, SOF inserted after the 2nd payload word -> err 5; the following valid frame is received OK.
//     Also K28.5 after the 1st word of a separate frame -> err 2; no m_last for that frame.
//  5. Assert rst during S_DATA -> outputs 0 next edge; the next complete frame passes with frame_ok.
//  6. Force 2^CNT_W+2 error frames (CNT_W overridden to 4) -> err_cnt saturates at 4'hF.

Source files
------------

// File: rtl/sfp_rx_deframer.sv
// SFP receive deframer: delineates SOF/EOF-bounded frames on the aligned 32-bit lane,
// strips header and checksum, streams payload words and reports per-frame status.
module sfp_rx_deframer #(
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      rxd,
  input  logic [3:0]       rxctl,
  output logic [31:0]      m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic [7:0]       m_type,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [7:0] K_IDLE = 8'hBC;
  localparam logic [7:0] K_SOF  = 8'hFB;
  localparam logic [7:0] K_EOF  = 8'hFD;

  localparam logic [2:0] E_LEN  = 3'd1;
  localparam logic [2:0] E_K    = 3'd2;
  localparam logic [2:0] E_CSUM = 3'd3;
  localparam logic [2:0] E_NEOF = 3'd4;
  localparam logic [2:0] E_SOF  = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_EOF} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_sum;
  logic [15:0] r_rem;
  logic        r_csum_ok;

  logic        w_ctl, w_data, w_sof, w_eof, w_len_bad;
  logic        w_emit, w_last, w_ok, w_err;
  logic [2:0]  w_code;

  // Word classification; only ctl=0001 carries a recognised control code.
  assign w_ctl     = (rxctl == 4'b0001);
  assign w_data    = (rxctl == 4'h0);
  assign w_sof     = w_ctl && (rxd[7:0] == K_SOF);
  assign w_eof     = w_ctl && (rxd[7:0] == K_EOF);
  assign w_len_bad = 32'(rxd[31:16]) > MAX_LEN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state: a SOF anywhere inside a frame resyncs onto the new header.
  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && w_sof) begin
      w_next = S_HDR;
    end else begin
      case (r_state)
        S_IDLE: if (w_sof) w_next = S_HDR;
        S_HDR: begin
          if (!w_data || w_len_bad)      w_next = S_IDLE;
          else if (rxd[31:16] == 16'd0)  w_next = S_CSUM;
          else                           w_next = S_DATA;
        end
        S_DATA: begin
          if (!w_data)              w_next = S_IDLE;
          else if (r_rem == 16'd1)  w_next = S_CSUM;
        end
        S_CSUM:  w_next = w_data ? S_EOF : S_IDLE;
        S_EOF:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Per-word decisions, registered below into the output stage.
  always_comb begin
    w_emit = 1'b0;
    w_last = 1'b0;
    w_ok   = 1'b0;
    w_err  = 1'b0;
    w_code = 3'd0;
    if (r_state != S_IDLE && w_sof) begin
      w_err  = 1'b1;
      w_code = E_SOF;
    end else begin
      case (r_state)
        S_HDR: begin
          if (!w_data)        begin w_err = 1'b1; w_code = E_K;   end
          else if (w_len_bad) begin w_err = 1'b1; w_code = E_LEN; end
        end
        S_DATA: begin
          if (w_data) begin
            w_emit = 1'b1;
            w_last = (r_rem == 16'd1);
          end else begin
            w_err  = 1'b1;
            w_code = E_K;
          end
        end
        S_CSUM: if (!w_data) begin w_err = 1'b1; w_code = E_K; end
        S_EOF: begin
          if (w_eof && r_csum_ok) w_ok = 1'b1;
          else if (w_eof)         begin w_err = 1'b1; w_code = E_CSUM; end
          else                    begin w_err = 1'b1; w_code = E_NEOF; end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data    <= 32'd0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_type    <= 8'd0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 3'd0;
      err_cnt   <= '0;
      r_sum     <= 32'd0;
      r_rem     <= 16'd0;
      r_csum_ok <= 1'b0;
    end else begin
      m_valid   <= w_emit;
      m_last    <= w_last;
      frame_ok  <= w_ok;
      frame_err <= w_err;
      err_code  <= w_code;
      if (w_emit) m_data <= rxd;
      if (w_err && err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
      if (r_state == S_HDR && w_data) begin
        m_type <= rxd[15:8];
        r_sum  <= rxd;
        r_rem  <= rxd[31:16];
      end
      if (r_state == S_DATA && w_data) begin
        r_sum <= r_sum + rxd;
        r_rem <= r_rem - 16'd1;
      end
      if (r_state == S_CSUM && w_data) r_csum_ok <= (rxd == r_sum);
    end
  end

endmodule
